// File: rtl/voting_pkg.sv
// voting_pkg: shared definitions for the booth vote arbiter.
//   - Default geometry constants (NUM_BOOTHS, BOOTH_W, NUM_CANDS, CAND_W).
//   - booth_state_t: the per-booth session state.
//   - sat_inc8: saturating +1 for the 8-bit event counters.
package voting_pkg;

  localparam int NUM_BOOTHS = 4;
  localparam int BOOTH_W    = 2;
  localparam int NUM_CANDS  = 4;
  localparam int CAND_W     = 2;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    ARMED   = 2'd1,
    PENDING = 2'd2
  } booth_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/booth_vote_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       in  N  request vector (one bit per requester)
//   ptr       in  W  highest-priority requester this cycle (must be < N)
//   grant     out N  one-hot grant, all zero when nothing requests
//   grant_idx out W  index of the granted requester (0 when none)
//   grant_any out 1  at least one requester was granted
// The search starts at ptr and wraps past N-1 back to 0.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_any
);

  int           idx;
  logic [W-1:0] idx_w;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      idx_w = W'(idx);
      if (!grant_any && req[idx_w]) begin
        grant[idx_w] = 1'b1;
        grant_idx    = idx_w;
        grant_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_vote_arbiter.sv
// booth_vote_arbiter: shares one vote-logging port between NUM_BOOTHS booths.
// Each booth runs LOCKED -> ARMED (officer arm) -> PENDING (vote captured)
// -> LOCKED (vote moved into the output slot). A round-robin arbiter picks
// which pending booth loads the single registered output slot.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-low
//   mode             in   0 = voting, 1 = result display (new votes dropped)
//   booth_arm        in   per-booth officer arm pulse
//   booth_vote_valid in   per-booth one-cycle vote pulse
//   booth_vote_cand  in   candidate of booth b at [b*CAND_W +: CAND_W]
//   booth_armed      out  booth is ARMED
//   booth_pending    out  booth holds an unlogged vote
//   log_valid/log_cand/log_booth out, log_ready in: output slot handshake
//   drop_count       out  saturating count of rejected votes
//   timeout_count    out  saturating count of arm timeouts (ARB_TIMEOUT_EN only)
//
// Handshake: the slot transfers on a rising edge where log_valid=1 and
// log_ready=1. While log_valid=1 and log_ready=0 the slot contents are held.
// The slot reloads whenever it is empty or is being accepted this cycle.
//
// Build option: define ARB_TIMEOUT_EN to add per-booth arm timers
// (ARM_TIMEOUT cycles) and the timeout_count output.
module booth_vote_arbiter
  import voting_pkg::*;
#(
  parameter int NUM_BOOTHS = voting_pkg::NUM_BOOTHS,
  parameter int NUM_CANDS  = voting_pkg::NUM_CANDS,
  parameter int CAND_W     = voting_pkg::CAND_W,
  parameter int BOOTH_W    = voting_pkg::BOOTH_W
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int ARM_TIMEOUT = 1000
`endif
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         mode,
  input  logic [NUM_BOOTHS-1:0]        booth_arm,
  input  logic [NUM_BOOTHS-1:0]        booth_vote_valid,
  input  logic [NUM_BOOTHS*CAND_W-1:0] booth_vote_cand,
  output logic [NUM_BOOTHS-1:0]        booth_armed,
  output logic [NUM_BOOTHS-1:0]        booth_pending,
  output logic                         log_valid,
  output logic [CAND_W-1:0]            log_cand,
  output logic [BOOTH_W-1:0]           log_booth,
  input  logic                         log_ready,
  output logic [7:0]                   drop_count
`ifdef ARB_TIMEOUT_EN
  ,
  output logic [7:0]                   timeout_count
`endif
);

  localparam logic [CAND_W:0]  CAND_LIMIT = (CAND_W + 1)'(NUM_CANDS);
  localparam logic [BOOTH_W-1:0] LAST_BOOTH = BOOTH_W'(NUM_BOOTHS - 1);

  booth_state_t      state     [NUM_BOOTHS];
  logic [CAND_W-1:0] pend_cand [NUM_BOOTHS];
  logic [CAND_W-1:0] vote_cand [NUM_BOOTHS];
  logic [BOOTH_W-1:0] rr_ptr;

  logic [NUM_BOOTHS-1:0] vote_ok;
  logic [NUM_BOOTHS-1:0] vote_drop;
  logic [NUM_BOOTHS-1:0] grant;
  logic [BOOTH_W-1:0]    grant_idx;
  logic                  grant_any;
  logic                  slot_load;
  logic                  do_grant;
  logic [CAND_W-1:0]     grant_cand;
  logic [7:0]            drop_next;

`ifdef ARB_TIMEOUT_EN
  localparam int TMR_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ARM_TIMEOUT - 1);

  logic [TMR_W-1:0]      arm_timer [NUM_BOOTHS];
  logic [NUM_BOOTHS-1:0] timeout_hit;
  logic [7:0]            timeout_next;
`endif

  // Decode state and classify this cycle's vote pulses.
  always_comb begin
    for (int b = 0; b < NUM_BOOTHS; b++) begin
      vote_cand[b]     = booth_vote_cand[b*CAND_W +: CAND_W];
      booth_armed[b]   = (state[b] == ARMED);
      booth_pending[b] = (state[b] == PENDING);
      vote_ok[b]       = booth_vote_valid[b] && !mode && (state[b] == ARMED) &&
                         ({1'b0, vote_cand[b]} < CAND_LIMIT);
      vote_drop[b]     = booth_vote_valid[b] && !vote_ok[b];
    end
  end

  // Several booths can be rejected in one cycle; each adds one, saturating.
  always_comb begin
    drop_next = drop_count;
    for (int b = 0; b < NUM_BOOTHS; b++) begin
      if (vote_drop[b]) drop_next = sat_inc8(drop_next);
    end
  end

`ifdef ARB_TIMEOUT_EN
  // A vote in the final armed cycle wins over the timeout.
  always_comb begin
    timeout_next = timeout_count;
    for (int b = 0; b < NUM_BOOTHS; b++) begin
      timeout_hit[b] = (state[b] == ARMED) && !vote_ok[b] && (arm_timer[b] == TMR_LAST);
      if (timeout_hit[b]) timeout_next = sat_inc8(timeout_next);
    end
  end
`endif

  rr_arbiter #(
    .N (NUM_BOOTHS),
    .W (BOOTH_W)
  ) u_rr_arbiter (
    .req       (booth_pending),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign slot_load = !log_valid || log_ready;
  assign do_grant  = slot_load && grant_any;

  always_comb begin
    grant_cand = '0;
    for (int b = 0; b < NUM_BOOTHS; b++) begin
      if (grant[b]) grant_cand = grant_cand | pend_cand[b];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BOOTHS; b++) begin
        state[b]     <= LOCKED;
        pend_cand[b] <= '0;
`ifdef ARB_TIMEOUT_EN
        arm_timer[b] <= '0;
`endif
      end
      rr_ptr     <= '0;
      log_valid  <= 1'b0;
      log_cand   <= '0;
      log_booth  <= '0;
      drop_count <= '0;
`ifdef ARB_TIMEOUT_EN
      timeout_count <= '0;
`endif
    end else begin
      for (int b = 0; b < NUM_BOOTHS; b++) begin
        case (state[b])
          LOCKED: begin
            if (booth_arm[b] && !mode) begin
              state[b] <= ARMED;
`ifdef ARB_TIMEOUT_EN
              arm_timer[b] <= '0;
`endif
            end
          end
          ARMED: begin
            if (vote_ok[b]) begin
              state[b]     <= PENDING;
              pend_cand[b] <= vote_cand[b];
            end
`ifdef ARB_TIMEOUT_EN
            else if (timeout_hit[b]) begin
              state[b] <= LOCKED;
            end else begin
              arm_timer[b] <= arm_timer[b] + TMR_W'(1);
            end
`endif
          end
          PENDING: begin
            if (do_grant && grant[b]) state[b] <= LOCKED;
          end
          default: state[b] <= LOCKED;
        endcase
      end

      if (do_grant) begin
        log_valid <= 1'b1;
        log_cand  <= grant_cand;
        log_booth <= grant_idx;
        rr_ptr    <= (grant_idx == LAST_BOOTH) ? '0 : grant_idx + BOOTH_W'(1);
      end else if (log_valid && log_ready) begin
        log_valid <= 1'b0;
      end

      drop_count <= drop_next;
`ifdef ARB_TIMEOUT_EN
      timeout_count <= timeout_next;
`endif
    end
  end

endmodule

// File: tb/tb_booth_vote_arbiter.sv
// tb_booth_vote_arbiter: randomized and directed stimulus against a
// behavioural model of the booth/slot rules. The model pushes each vote it
// expects to be logged onto exp_q; the monitor pops and compares whenever
// the DUT's slot is accepted. Booth status and counters are compared each
// cycle. Inputs change on the falling edge; the monitor samples 1 time unit
// later and the model advances 2 time units later.
module tb_booth_vote_arbiter;

  localparam int NB  = 4;
  localparam int NC  = 4;
  localparam int CW  = 3;
  localparam int BW  = 2;
`ifdef ARB_TIMEOUT_EN
  localparam int TMO = 10;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              mode = 1'b0;
  logic [NB-1:0]     booth_arm = '0;
  logic [NB-1:0]     booth_vote_valid = '0;
  logic [NB*CW-1:0]  booth_vote_cand = '0;
  logic [NB-1:0]     booth_armed;
  logic [NB-1:0]     booth_pending;
  logic              log_valid;
  logic [CW-1:0]     log_cand;
  logic [BW-1:0]     log_booth;
  logic              log_ready = 1'b0;
  logic [7:0]        drop_count;
`ifdef ARB_TIMEOUT_EN
  logic [7:0]        timeout_count;
`endif

  booth_vote_arbiter #(
    .NUM_BOOTHS (NB),
    .NUM_CANDS  (NC),
    .CAND_W     (CW),
    .BOOTH_W    (BW)
`ifdef ARB_TIMEOUT_EN
    ,
    .ARM_TIMEOUT (TMO)
`endif
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .mode             (mode),
    .booth_arm        (booth_arm),
    .booth_vote_valid (booth_vote_valid),
    .booth_vote_cand  (booth_vote_cand),
    .booth_armed      (booth_armed),
    .booth_pending    (booth_pending),
    .log_valid        (log_valid),
    .log_cand         (log_cand),
    .log_booth        (log_booth),
    .log_ready        (log_ready),
    .drop_count       (drop_count)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_count    (timeout_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [BW+CW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Booth session: 0 = locked, 1 = armed, 2 = holding a vote.
  int m_sess [NB];
  int m_cand [NB];
  int m_age  [NB];
  int m_ptr;
  bit m_slot;
  int m_drops;
  int m_tmo;

  function automatic logic [NB-1:0] sess_mask(input int v);
    logic [NB-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) m[b] = (m_sess[b] == v);
    return m;
  endfunction

  always @(negedge clock) begin
    #2;
    if (!reset) begin
      for (int b = 0; b < NB; b++) begin
        m_sess[b] = 0;
        m_cand[b] = 0;
        m_age[b]  = 0;
      end
      m_ptr = 0; m_slot = 0; m_drops = 0; m_tmo = 0;
      exp_q.delete();
    end else begin
      int old_sess [NB];
      int g;
      for (int b = 0; b < NB; b++) old_sess[b] = m_sess[b];

      for (int b = 0; b < NB; b++) begin
        int c;
        bit voted;
        c = int'(booth_vote_cand[b*CW +: CW]);
        voted = 0;
        if (booth_vote_valid[b]) begin
          if (old_sess[b] == 1 && mode == 1'b0 && c < NC) begin
            m_sess[b] = 2;
            m_cand[b] = c;
            voted = 1;
          end else if (m_drops < 255) begin
            m_drops = m_drops + 1;
          end
        end
        if (old_sess[b] == 0 && booth_arm[b] && mode == 1'b0) begin
          m_sess[b] = 1;
          m_age[b]  = 0;
        end
`ifdef ARB_TIMEOUT_EN
        if (old_sess[b] == 1 && !voted) begin
          m_age[b] = m_age[b] + 1;
          if (m_age[b] == TMO) begin
            m_sess[b] = 0;
            if (m_tmo < 255) m_tmo = m_tmo + 1;
          end
        end
`endif
      end

      // Grant the first booth holding a vote at or after the pointer.
      g = -1;
      if (!m_slot || log_ready) begin
        for (int i = 0; i < NB; i++) begin
          int b;
          b = (m_ptr + i) % NB;
          if (g < 0 && old_sess[b] == 2) g = b;
        end
      end
      if (g >= 0) begin
        exp_q.push_back({BW'(g), CW'(m_cand[g])});
        m_sess[g] = 0;
        m_slot    = 1;
        m_ptr     = (g + 1) % NB;
      end else if (m_slot && log_ready) begin
        m_slot = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    #1;
    if (!reset) begin
      check("reset_outputs",
            {log_valid, 5'(log_cand), 3'(log_booth), drop_count, booth_armed, booth_pending},
            64'd0);
    end else begin
      check("booth_armed", booth_armed, sess_mask(1));
      check("booth_pending", booth_pending, sess_mask(2));
      check("drop_count", drop_count, m_drops);
`ifdef ARB_TIMEOUT_EN
      check("timeout_count", timeout_count, m_tmo);
`endif
      check("log_valid", log_valid, exp_q.size() != 0);
      if (log_valid && exp_q.size() != 0) begin
        check("log_booth_cand", {log_booth, log_cand}, exp_q[0]);
        if (log_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [NB-1:0] arm, input logic [NB-1:0] vote,
                     input logic [NB*CW-1:0] cands, input logic md, input logic rdy);
    @(negedge clock);
    booth_arm        = arm;
    booth_vote_valid = vote;
    booth_vote_cand  = cands;
    mode             = md;
    log_ready        = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc('0, '0, '0, 1'b0, rdy);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    booth_arm = '0; booth_vote_valid = '0; mode = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic logic [NB*CW-1:0] all_cand(input int c);
    logic [NB*CW-1:0] v;
    for (int b = 0; b < NB; b++) v[b*CW +: CW] = CW'(c);
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b1;
    idle(2, 1'b1);

    // Single vote: booth 0, candidate 2.
    cyc(4'b0001, '0, '0, 1'b0, 1'b1);
    cyc('0, 4'b0001, all_cand(2), 1'b0, 1'b1);
    idle(4, 1'b1);

    // Four simultaneous votes, twice.
    for (int r = 0; r < 2; r++) begin
      cyc(4'b1111, '0, '0, 1'b0, 1'b1);
      cyc('0, 4'b1111, all_cand(1), 1'b0, 1'b1);
      idle(6, 1'b1);
    end

    // Stall: slot full while the logger is not ready.
    cyc(4'b0110, '0, '0, 1'b0, 1'b0);
    cyc('0, 4'b0110, all_cand(3), 1'b0, 1'b0);
    idle(6, 1'b0);
    idle(4, 1'b1);

    // Drops: unarmed booth, out-of-range candidate, display mode.
    pulse_reset();
    cyc('0, 4'b0010, all_cand(0), 1'b0, 1'b1);
    cyc(4'b1001, '0, '0, 1'b0, 1'b1);
    cyc('0, 4'b0001, all_cand(5), 1'b0, 1'b1);
    cyc('0, 4'b1000, all_cand(1), 1'b1, 1'b1);
    idle(1, 1'b1);
    #1 check("drop_count_three", drop_count, 8'd3);
    check("no_log_after_drops", log_valid, 1'b0);
    for (int i = 0; i < 65; i++) cyc('0, 4'b1111, all_cand(5), 1'b0, 1'b1);
    idle(1, 1'b1);
    #1 check("drop_count_saturated", drop_count, 8'd255);

    // Pending votes drain after switching to display mode.
    pulse_reset();
    cyc(4'b1001, '0, '0, 1'b0, 1'b0);
    cyc('0, 4'b1001, all_cand(2), 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc('0, '0, '0, 1'b1, 1'b1);
    cyc('0, '0, '0, 1'b1, 1'b1);
    cyc('0, '0, '0, 1'b1, 1'b1);
    cyc(4'b1000, '0, '0, 1'b1, 1'b1);
    cyc('0, '0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Reset while the slot is full and two booths hold votes.
    cyc(4'b0111, '0, '0, 1'b0, 1'b0);
    cyc('0, 4'b0111, all_cand(3), 1'b0, 1'b0);
    idle(2, 1'b0);
    pulse_reset();
    idle(3, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // Armed booth with no vote returns to locked after TMO cycles.
    pulse_reset();
    cyc(4'b0001, '0, '0, 1'b0, 1'b1);
    idle(TMO + 3, 1'b1);
    #1 check("timeout_count_one", timeout_count, 8'd1);
`endif

    // Randomized phase with periodic resets.
    for (int i = 0; i < 3000; i++) begin
      logic [NB-1:0]    arm_r, vote_r;
      logic [NB*CW-1:0] cand_r;
      if (i % 400 == 399) begin
        pulse_reset();
      end else begin
        for (int b = 0; b < NB; b++) begin
          arm_r[b]              = ($urandom_range(0, 3) == 0);
          vote_r[b]             = ($urandom_range(0, 3) == 0);
          cand_r[b*CW +: CW]    = CW'($urandom_range(0, 7));
        end
        cyc(arm_r, vote_r, cand_r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
      end
    end

    idle(8, 1'b1);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
